// File: rtl/writeback_regfile_segmented.sv
// writeback_regfile_segmented
//   Write-back stage of a RISC-V style pipeline combined with the integer
//   register file (x1..x31, x0 hard-wired to zero) and a retired-instruction
//   counter.
//
// Ports
//   clk             : single clock, all state updates on the rising edge
//   reset           : synchronous, active-high; clears registers and instret
//   wb_valid        : MEM/WB slot holds a real instruction (0 = bubble)
//   reg_write       : write rd this cycle
//   mem_to_reg      : select load data as the write-back value
//   jump_rd         : select link address (highest priority)
//   alu_result      : ALU result
//   data_memory_out : load data
//   pc_plus4        : link address for JAL/JALR
//   rd_addr         : destination register
//   rs1_addr/rs2_addr : decode-stage read addresses
//   rs1_data/rs2_data : combinational read data with write-through bypass
//   wb_data         : selected write-back value (combinational)
//   wb_en           : a register write is performed this cycle
//   instret         : count of retired instructions, wraps silently
module writeback_regfile_segmented #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_valid,
    input  logic              reg_write,
    input  logic              mem_to_reg,
    input  logic              jump_rd,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] data_memory_out,
    input  logic [DATA_W-1:0] pc_plus4,
    input  logic [4:0]        rd_addr,
    input  logic [4:0]        rs1_addr,
    input  logic [4:0]        rs2_addr,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_en,
    output logic [CNT_W-1:0]  instret
);

    // x0 has no storage; only x1..x31 exist.
    logic [DATA_W-1:0] regs [1:31];

    always_comb begin
        if (jump_rd)
            wb_data = pc_plus4;
        else if (mem_to_reg)
            wb_data = data_memory_out;
        else
            wb_data = alu_result;
    end

    assign wb_en = wb_valid & reg_write & (rd_addr != 5'd0) & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 1; i <= 31; i++)
                regs[i] <= '0;
            instret <= '0;
        end else begin
            for (int unsigned i = 1; i <= 31; i++)
                if (wb_en && rd_addr == 5'(i))
                    regs[i] <= wb_data;
            if (wb_valid)
                instret <= instret + CNT_W'(1);
        end
    end

    // Read ports: zero for x0 and while reset is held (stored state may not
    // be cleared until the reset edge); otherwise bypass the in-flight write,
    // else the stored value.
    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        for (int unsigned i = 1; i <= 31; i++) begin
            if (rs1_addr == 5'(i))
                rs1_data = regs[i];
            if (rs2_addr == 5'(i))
                rs2_data = regs[i];
        end
        if (wb_en && rs1_addr == rd_addr)
            rs1_data = wb_data;
        if (wb_en && rs2_addr == rd_addr)
            rs2_data = wb_data;
        if (reset || rs1_addr == 5'd0)
            rs1_data = '0;
        if (reset || rs2_addr == 5'd0)
            rs2_data = '0;
    end

endmodule
